// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and one-cycle trap-code stage.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
`ifndef TRAP_STALL
`define TRAP_STALL 8'h80
`endif

module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_index,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wen,
  input  logic [ADDR_W-1:0]        windex0,
  input  logic [ADDR_W-1:0]        windex1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_index,
  input  logic [7:0]               exception_in,
  output logic [7:0]               exception
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] store_q, store_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [7:0]                   exc_q, exc_d;

  logic quiet;
  logic wr0, wr1, clm;

  assign quiet = (exception_in == 8'h00);
  assign wr0   = quiet && wen[0] && (windex0 != '0);
  assign wr1   = quiet && wen[1] && (windex1 != '0);
  assign clm   = quiet && claim_en && (claim_index != '0);

  // Port 1 is applied after port 0 and the claim last, so they win ties.
  always_comb begin
    store_d = store_q;
    busy_d  = busy_q;
    exc_d   = exception_in;
    if (wr0) begin
      store_d[windex0] = wdata0;
      busy_d[windex0]  = 1'b0;
    end
    if (wr1) begin
      store_d[windex1] = wdata1;
      busy_d[windex1]  = 1'b0;
    end
    if (clm) begin
      busy_d[claim_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= '0;
      busy_q  <= '0;
      exc_q   <= `TRAP_STALL;
    end else begin
      store_q <= store_d;
      busy_q  <= busy_d;
      exc_q   <= exc_d;
    end
  end

  assign exception = exc_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] d;
    logic              b;
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1, hitc;
    assign hit0 = wr0 && (windex0 == idx);
    assign hit1 = wr1 && (windex1 == idx);
    assign hitc = clm && (claim_index == idx);
`endif

    assign idx = rd_index[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = store_q[idx];
      b = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
      if (hit0) begin
        d = wdata0;
        b = 1'b0;
      end
      if (hit1) begin
        d = wdata1;
        b = 1'b0;
      end
      if ((hit0 || hit1) && hitc) begin
        b = 1'b1;
      end
`endif
      if (rst || idx == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k] = b;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the pipeline register file in the datapath.
- Provides NUM_RD combinational read ports and two write ports (ALU/writeback and load return).
- Keeps a per-register busy scoreboard so decode can detect pending writes and raise stalls.
- Propagates the pipeline exception/trap code one cycle, suppressing state updates while an exception is in flight.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W registers, register 0 hardwired to zero
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_index  input  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  1 = indexed register has a pending claimed write
- wen  input  2  write enables, bit0 = port 0, bit1 = port 1
- windex0, windex1  input  ADDR_W each  write indices
- wdata0, wdata1  input  DATA_W each  write data
- claim_en  input  1  mark claim_index busy (producer issued)
- claim_index  input  ADDR_W  register to mark busy
- exception_in  input  8  incoming trap code, nonzero = exception
- exception  output  8  registered trap code to next stage

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - all registers = 0, all busy bits = 0, exception = TRAP_STALL.
  - rd_data reads 0 and rd_busy reads 0 while rst=1.
- Reads: combinational. rd_data[k] = store[rd_index[k]]; rd_busy[k] = busy[rd_index[k]]. Index 0 always reads data 0 and busy 0.
- Each clock edge, exception_in != 0:
  - exception <= exception_in.
  - No register, busy or claim update: writes and claims are dropped.
- Each clock edge, exception_in == 0:
  - exception <= 0.
  - Port p with wen[p]=1 and windex_p != 0: store[windex_p] <= wdata_p; busy[windex_p] <= 0.
  - Both ports write the same nonzero index: port 1 data wins; busy cleared.
  - claim_en=1 and claim_index != 0: busy[claim_index] <= 1.
  - Claim takes priority over a same-cycle write to the same index: data written, busy stays 1.
  - Writes or claims to index 0 are ignored.
- Write latency: data is visible on reads in the cycle after the edge (no bypass, unless the optional feature is enabled).
- Reset mid-operation: pending writes and claims are lost; the scoreboard is cleared.
- TRAP_STALL is the codebase's global trap-code define, not a parameter.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read bypass.
  - If wen[p]=1, windex_p == rd_index[k] != 0 and exception_in == 0, then rd_data[k] = wdata_p (port 1 over port 0) and rd_busy[k] = 0.
  - A same-cycle claim of that index still forces rd_busy[k] = 1.
- Undefined: reads return stored contents only; the bypass logic is absent.

Test Plan:
- Assert rst mid-cycle after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately; exception = TRAP_STALL; after release with exception_in=0 and one edge, exception = 0.
- wen=2'b11, windex0=windex1=7, wdata0=0x11, wdata1=0x22 -> next cycle r7 reads 0x22; write to r0 with 0xFFFF -> r0 still reads 0.
- Claim r9, then write r9=0x1234 two cycles later -> rd_busy=1 for the intermediate cycles, then 0 with data 0x1234. Claim and write r9 in the same cycle -> data 0x1234, busy 1.
- exception_in=0x05 with wen=1, windex0=3, wdata0=0xAA, claim_en=1 for r4 -> exception=0x05; r3 unchanged; r4 not busy.
- NUM_RD=3, ADDR_W=4, DATA_W=16: write r15=0xBEEF, then read ports on 15, 0, 15 -> 0xBEEF, 0x0000, 0xBEEF.
- With REGFILE_BYPASS_EN: write r2=0x55 while rd_index[0]=2 -> rd_data[0]=0x55 in the same cycle. Without the macro -> old value that cycle, 0x55 the next.
